// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared widths and packet types for the common data bus
//               arbiter and its per-FU completion FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int ROBLEN = 32;
    localparam int TW     = $clog2(ROBLEN);
    localparam int REGW   = 5;

    localparam int DEF_NUM_FU     = 4;
    localparam int DEF_CDB_WIDTH  = 3;
    localparam int DEF_FIFO_DEPTH = 2;

    // One completed result as produced by a functional unit
    typedef struct packed {
        logic [TW-1:0]   T;
        logic [XLEN-1:0] value;
        logic [REGW-1:0] dest_reg_idx;
    } fu_cdb_packet_t;

    // One broadcast slot as seen by the reservation stations / ROB / map table
    typedef struct packed {
        logic           valid;
        fu_cdb_packet_t pkt;
    } cdb_rs_packet_t;

endpackage

`default_nettype wire

// File: rtl/cdb_fu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_fu_fifo
// Description : Small completion FIFO for one functional unit. Ready is
//               derived only from the registered count, so a pop in the
//               same cycle never frees a slot for a push.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           squash,
    input  logic           push,
    input  fu_cdb_packet_t din,
    input  logic           pop,
    output fu_cdb_packet_t dout,
    output logic           empty,
    output logic           ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    fu_cdb_packet_t     r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Ready is held low for the whole time reset is asserted
    assign ready  = reset & (r_count < c_depth);
    assign empty  = (r_count == '0);
    assign w_push = push & ready;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_head];

    // Pointer and occupancy tracking; squash discards everything including this cycle's push
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + c_ptr_w'(1);
            if (w_pop)  r_head <= r_head + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clock) begin
        if (w_push && !squash) r_mem[r_tail] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Collects FU completions into per-FU FIFOs and broadcasts up
//               to CDB_WIDTH of them per cycle on the common data bus, using
//               a rotating priority pointer so no FU starves.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = DEF_NUM_FU,
    parameter int CDB_WIDTH  = DEF_CDB_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash_flag,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*TW-1:0]        fu_T,
    input  logic [NUM_FU*XLEN-1:0]      fu_value,
    input  logic [NUM_FU*REGW-1:0]      fu_dest_reg,
    output logic [NUM_FU-1:0]           fu_ready,
    output logic [CDB_WIDTH-1:0]        cdb_valid,
    output logic [CDB_WIDTH*TW-1:0]     cdb_T,
    output logic [CDB_WIDTH*XLEN-1:0]   cdb_value,
    output logic [CDB_WIDTH*REGW-1:0]   cdb_dest_reg
);

    localparam int c_rr_w   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int c_cnt_w  = $clog2(CDB_WIDTH + 1);
    localparam int c_slot_w = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;
    localparam logic [c_rr_w:0]    c_num_fu = (c_rr_w + 1)'(NUM_FU);
    localparam logic [c_cnt_w-1:0] c_cdb_w  = c_cnt_w'(CDB_WIDTH);

    fu_cdb_packet_t     w_din  [NUM_FU];
    fu_cdb_packet_t     w_head [NUM_FU];
    logic [NUM_FU-1:0]  w_empty;
    logic [NUM_FU-1:0]  w_grant;
    cdb_rs_packet_t     w_sel  [CDB_WIDTH];
    cdb_rs_packet_t     r_slot [CDB_WIDTH];
    logic [c_cnt_w-1:0] w_n;
    logic [c_rr_w:0]    w_sum;
    logic [c_rr_w-1:0]  w_idx;
    logic [c_rr_w-1:0]  w_last;
    logic [c_rr_w:0]    w_nxt;
    logic [c_rr_w-1:0]  w_rr_next;
    logic [c_rr_w-1:0]  r_rr_ptr;

    generate
        for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
            assign w_din[i] = '{T:            fu_T[i*TW +: TW],
                                value:        fu_value[i*XLEN +: XLEN],
                                dest_reg_idx: fu_dest_reg[i*REGW +: REGW]};

            cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
                .clock  (clock),
                .reset  (reset),
                .squash (squash_flag),
                .push   (fu_valid[i]),
                .din    (w_din[i]),
                .pop    (w_grant[i]),
                .dout   (w_head[i]),
                .empty  (w_empty[i]),
                .ready  (fu_ready[i])
            );
        end
    endgenerate

    // Rotating-priority scan: first CDB_WIDTH non-empty heads from rr_ptr fill slots in order
    always_comb begin
        w_grant = '0;
        w_sel   = '{default: '0};
        w_n     = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_last  = r_rr_ptr;
        for (int k = 0; k < NUM_FU; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_rr_w + 1)'(k);
            if (w_sum >= c_num_fu) w_sum = w_sum - c_num_fu;
            w_idx = w_sum[c_rr_w-1:0];
            if (!w_empty[w_idx] && (w_n < c_cdb_w)) begin
                w_grant[w_idx]              = 1'b1;
                w_sel[w_n[c_slot_w-1:0]]    = '{valid: 1'b1, pkt: w_head[w_idx]};
                w_last                      = w_idx;
                w_n                         = w_n + c_cnt_w'(1);
            end
        end
        w_nxt = {1'b0, w_last} + (c_rr_w + 1)'(1);
        if (w_nxt >= c_num_fu) w_nxt = '0;
        w_rr_next = (w_n != '0) ? w_nxt[c_rr_w-1:0] : r_rr_ptr;
    end

    // Broadcast register and priority pointer; squash blanks the bus and restarts at FU0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot   <= '{default: '0};
            r_rr_ptr <= '0;
        end else if (squash_flag) begin
            r_slot   <= '{default: '0};
            r_rr_ptr <= '0;
        end else begin
            r_slot   <= w_sel;
            r_rr_ptr <= w_rr_next;
        end
    end

    generate
        for (genvar s = 0; s < CDB_WIDTH; s++) begin : g_out
            assign cdb_valid[s]                   = r_slot[s].valid;
            assign cdb_T[s*TW +: TW]              = r_slot[s].pkt.T;
            assign cdb_value[s*XLEN +: XLEN]      = r_slot[s].pkt.value;
            assign cdb_dest_reg[s*REGW +: REGW]   = r_slot[s].pkt.dest_reg_idx;
        end
    endgenerate

endmodule

`default_nettype wire
